// File: rtl/ball_motion_ctrl_if.sv
// Ball/brick collision query bus: the ball controller drives position, speed and
// request; the brick field answers with acknowledge, collision flag and direction.
interface ball_motion_ctrl_if #(
  parameter int PIXELX_BIT_CNT    = 10,
  parameter int PIXELY_BIT_CNT    = 10,
  parameter int BALL_SIZE_BIT_CNT = 3,
  parameter int DIR_BIT_CNT       = 5
);
  logic [PIXELX_BIT_CNT-1:0]    o_ballX;
  logic [PIXELY_BIT_CNT-1:0]    o_ballY;
  logic [BALL_SIZE_BIT_CNT-1:0] o_ball_size;
  logic [1:0]                   o_speedX;
  logic [1:0]                   o_speedY;
  logic                         o_brick_req;
  logic                         i_brick_ack;
  logic                         i_ball_brick_collision;
  logic [DIR_BIT_CNT-1:0]       i_direc_var;

  modport master (
    output o_ballX, o_ballY, o_ball_size, o_speedX, o_speedY, o_brick_req,
    input  i_brick_ack, i_ball_brick_collision, i_direc_var
  );

  modport slave (
    input  o_ballX, o_ballY, o_ball_size, o_speedX, o_speedY, o_brick_req,
    output i_brick_ack, i_ball_brick_collision, i_direc_var
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball mover and initiator of the brick collision handshake.
// Optional feature macro: BALL_TIMEOUT_EN (bounded wait for the brick acknowledge).
module ball_motion_ctrl #(
  parameter int X_INIT            = 320,
  parameter int Y_INIT            = 400,
  parameter int BALL_SIZE         = 4,
  parameter int X_MIN             = 32,
  parameter int X_MAX             = 607,
  parameter int Y_MIN             = 0,
  parameter int Y_BOTTOM          = 479,
  parameter int TIMEOUT           = 15,
  parameter int PIXELX_BIT_CNT    = 10,
  parameter int PIXELY_BIT_CNT    = 10,
  parameter int BALL_SIZE_BIT_CNT = 3,
  parameter int DIR_BIT_CNT       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame_tick,
  input  logic               i_launch,
  input  logic               i_restart,
  ball_motion_ctrl_if.master brick_if,
  output logic               o_ball_lost,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int XW = PIXELX_BIT_CNT;
  localparam int YW = PIXELY_BIT_CNT;
  localparam int XE = XW + 1;
  localparam int YE = YW + 1;
  localparam int DW = DIR_BIT_CNT;

  localparam logic [XW-1:0] X_RESET = XW'(X_INIT);
  localparam logic [YW-1:0] Y_RESET = YW'(Y_INIT);
  localparam logic [XE-1:0] X_LO    = XE'(X_MIN + BALL_SIZE);
  localparam logic [XE-1:0] X_HI    = XE'(X_MAX);
  localparam logic [XE-1:0] BS_X    = XE'(BALL_SIZE);
  localparam logic [YE-1:0] Y_LO    = YE'(Y_MIN + BALL_SIZE);
  localparam logic [YE-1:0] Y_LOSS  = YE'(Y_BOTTOM);
  localparam logic [YE-1:0] BS_Y    = YE'(BALL_SIZE);

  localparam logic [DW-1:0] DIR_FLIP_Y  = DW'(19);
  localparam logic [DW-1:0] DIR_FLIP_XY = DW'(18);

  localparam logic [1:0] SPD_ZERO = 2'b00;
  localparam logic [1:0] SPD_POS  = 2'b01;
  localparam logic [1:0] SPD_NEG  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_MOVE,
    S_REQ,
    S_WAIT_ACK,
    S_APPLY
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [1:0]      sx_q, sx_d;
  logic [1:0]      sy_q, sy_d;
  logic            req_q, req_d;
  logic            coll_q, coll_d;
  logic [DW-1:0]   dir_q, dir_d;
  logic            lost_q, lost_d;
  logic            busy_q, busy_d;

`ifdef BALL_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic [XE-1:0]   nx_ext;
  logic [YE-1:0]   ny_ext;
  logic            hit_left, hit_right, hit_top, hit_loss;

  // 01 <-> 11; a stopped axis stays stopped.
  function automatic logic [1:0] neg_speed(input logic [1:0] s);
    case (s)
      SPD_POS: neg_speed = SPD_NEG;
      SPD_NEG: neg_speed = SPD_POS;
      default: neg_speed = SPD_ZERO;
    endcase
  endfunction

  assign nx     = x_q + {{(XW-2){sx_q[1]}}, sx_q};
  assign ny     = y_q + {{(YW-2){sy_q[1]}}, sy_q};
  assign nx_ext = {1'b0, nx};
  assign ny_ext = {1'b0, ny};

  // Limits are compared one bit wider so that +/- BALL_SIZE never wraps.
  assign hit_left  = (nx_ext <= X_LO);
  assign hit_right = ((nx_ext + BS_X) >= X_HI);
  assign hit_top   = (ny_ext <= Y_LO);
  assign hit_loss  = ((ny_ext + BS_Y) >= Y_LOSS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= X_RESET;
      y_q       <= Y_RESET;
      sx_q      <= SPD_ZERO;
      sy_q      <= SPD_ZERO;
      req_q     <= 1'b0;
      coll_q    <= 1'b0;
      dir_q     <= '0;
      lost_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef BALL_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      req_q     <= req_d;
      coll_q    <= coll_d;
      dir_q     <= dir_d;
      lost_q    <= lost_d;
      busy_q    <= busy_d;
`ifdef BALL_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    req_d     = req_q;
    coll_d    = coll_q;
    dir_d     = dir_q;
    lost_d    = 1'b0;
`ifdef BALL_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        x_d   = X_RESET;
        y_d   = Y_RESET;
        sx_d  = SPD_ZERO;
        sy_d  = SPD_ZERO;
        req_d = 1'b0;
        if (i_launch) begin
          sx_d    = SPD_POS;
          sy_d    = SPD_NEG;
          state_d = S_WAIT_FRAME;
        end
      end

      S_WAIT_FRAME: begin
        if (i_frame_tick) state_d = S_MOVE;
      end

      S_MOVE: begin
        x_d = nx;
        y_d = ny;
        if (hit_left)  sx_d = SPD_POS;
        if (hit_right) sx_d = SPD_NEG;
        if (hit_top)   sy_d = SPD_POS;
        if (hit_loss) begin
          lost_d  = 1'b1;
          x_d     = X_RESET;
          y_d     = Y_RESET;
          sx_d    = SPD_ZERO;
          sy_d    = SPD_ZERO;
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        req_d   = 1'b1;
        state_d = S_WAIT_ACK;
`ifdef BALL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_WAIT_ACK: begin
        if (brick_if.i_brick_ack) begin
          coll_d  = brick_if.i_ball_brick_collision;
          dir_d   = brick_if.i_direc_var;
          req_d   = 1'b0;
          state_d = S_APPLY;
        end
`ifdef BALL_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          coll_d    = 1'b0;
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_APPLY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_APPLY: begin
        // Speeds here already carry any wall bounce from MOVE.
        if (coll_q) begin
          if (dir_q == DIR_FLIP_Y) begin
            sy_d = neg_speed(sy_q);
          end else if (dir_q == DIR_FLIP_XY) begin
            sx_d = neg_speed(sx_q);
            sy_d = neg_speed(sy_q);
          end
        end
        state_d = S_WAIT_FRAME;
      end

      default: state_d = S_IDLE;
    endcase

    if (i_restart) begin
      state_d   = S_IDLE;
      x_d       = X_RESET;
      y_d       = Y_RESET;
      sx_d      = SPD_ZERO;
      sy_d      = SPD_ZERO;
      req_d     = 1'b0;
      lost_d    = 1'b0;
`ifdef BALL_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end

    busy_d = (state_d == S_MOVE) || (state_d == S_REQ) || (state_d == S_WAIT_ACK);
  end

  assign brick_if.o_ballX     = x_q;
  assign brick_if.o_ballY     = y_q;
  assign brick_if.o_ball_size = BALL_SIZE_BIT_CNT'(BALL_SIZE);
  assign brick_if.o_speedX    = sx_q;
  assign brick_if.o_speedY    = sy_q;
  assign brick_if.o_brick_req = req_q;

  assign o_ball_lost = lost_q;
  assign o_busy      = busy_q;
`ifdef BALL_TIMEOUT_EN
  assign o_timeout   = timeout_q;
`else
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: launch, brick hits, walls, loss,
// handshake timing, restart and asynchronous reset.
module tb_ball_motion_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic i_frame_tick;
  logic i_launch;
  logic i_restart;
  logic o_ball_lost;
  logic o_busy;
  logic o_timeout;

  ball_motion_ctrl_if bif ();

  ball_motion_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_tick (i_frame_tick),
    .i_launch     (i_launch),
    .i_restart    (i_restart),
    .brick_if     (bif),
    .o_ball_lost  (o_ball_lost),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   req_rises  = 0;
  int   lost_cnt   = 0;
  logic req_prev   = 1'b0;

  always @(negedge clk) begin
    if (bif.o_brick_req && !req_prev) req_rises++;
    req_prev = bif.o_brick_req;
    if (o_ball_lost) lost_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ack(input logic a, input logic coll, input logic [4:0] dir);
    bif.i_brick_ack            = a;
    bif.i_ball_brick_collision = coll;
    bif.i_direc_var            = dir;
  endtask

  // Full frame with checks at every cycle from tick edge k through k+5.
  task automatic frame_checked(input string tag, input logic coll, input logic [4:0] dir,
                               input int ex, input int ey,
                               input logic [1:0] msx, input logic [1:0] msy,
                               input logic [1:0] fsx, input logic [1:0] fsy);
    int base;
    base = req_rises;
    i_frame_tick = 1'b1;
    step();                                   // k
    i_frame_tick = 1'b0;
    check_eq({tag, ".busy_move"}, o_busy, 1);
    step();                                   // k+1
    check_eq({tag, ".x"}, bif.o_ballX, ex);
    check_eq({tag, ".y"}, bif.o_ballY, ey);
    check_eq({tag, ".sx_move"}, bif.o_speedX, msx);
    check_eq({tag, ".sy_move"}, bif.o_speedY, msy);
    check_eq({tag, ".req_k1"}, bif.o_brick_req, 0);
    step();                                   // k+2
    check_eq({tag, ".req_k2"}, bif.o_brick_req, 1);
    step();                                   // k+3
    check_eq({tag, ".req_k3"}, bif.o_brick_req, 1);
    drive_ack(1'b1, coll, dir);
    step();                                   // k+4
    drive_ack(1'b0, 1'b0, 5'd0);
    check_eq({tag, ".req_k4"}, bif.o_brick_req, 0);
    check_eq({tag, ".sx_k4"}, bif.o_speedX, msx);
    check_eq({tag, ".sy_k4"}, bif.o_speedY, msy);
    check_eq({tag, ".timeout"}, o_timeout, 0);
    step();                                   // k+5
    check_eq({tag, ".sx_final"}, bif.o_speedX, fsx);
    check_eq({tag, ".sy_final"}, bif.o_speedY, fsy);
    check_eq({tag, ".busy_done"}, o_busy, 0);
    check_eq({tag, ".req_pulses"}, req_rises - base, 1);
    $display("frame %s: x=%0d y=%0d sx=%b sy=%b", tag, bif.o_ballX, bif.o_ballY,
             bif.o_speedX, bif.o_speedY);
  endtask

  // Plain frame used to walk the ball across the field.
  task automatic run_frame(input logic coll, input logic [4:0] dir);
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    step();
    step();
    check_eq("run.req", bif.o_brick_req, 1);
    step();
    drive_ack(1'b1, coll, dir);
    step();
    drive_ack(1'b0, 1'b0, 5'd0);
    step();
    $display("frame run: x=%0d y=%0d sx=%b sy=%b", bif.o_ballX, bif.o_ballY,
             bif.o_speedX, bif.o_speedY);
  endtask

  task automatic launch();
    i_launch = 1'b1;
    step();
    i_launch = 1'b0;
  endtask

  initial begin
    int base_r;
    int base_l;
    rst_n        = 1'b0;
    i_frame_tick = 1'b0;
    i_launch     = 1'b0;
    i_restart    = 1'b0;
    drive_ack(1'b0, 1'b0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values
    check_eq("rst.x", bif.o_ballX, 320);
    check_eq("rst.y", bif.o_ballY, 400);
    check_eq("rst.sx", bif.o_speedX, 0);
    check_eq("rst.sy", bif.o_speedY, 0);
    check_eq("rst.req", bif.o_brick_req, 0);
    check_eq("rst.lost", o_ball_lost, 0);
    check_eq("rst.busy", o_busy, 0);
    check_eq("rst.timeout", o_timeout, 0);
    check_eq("rst.size", bif.o_ball_size, 4);
    $display("reset: x=%0d y=%0d", bif.o_ballX, bif.o_ballY);

    // A tick while idle does nothing
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    step();
    check_eq("idle_tick.busy", o_busy, 0);
    check_eq("idle_tick.x", bif.o_ballX, 320);

    launch();
    check_eq("launch.sx", bif.o_speedX, 2'b01);
    check_eq("launch.sy", bif.o_speedY, 2'b11);
    check_eq("launch.busy", o_busy, 0);
    $display("launch: sx=%b sy=%b", bif.o_speedX, bif.o_speedY);

    frame_checked("f1_nocoll", 1'b0, 5'd0,  321, 399, 2'b01, 2'b11, 2'b01, 2'b11);
    frame_checked("f2_dir19",  1'b1, 5'd19, 322, 398, 2'b01, 2'b11, 2'b01, 2'b01);
    frame_checked("f3_dir18",  1'b1, 5'd18, 323, 399, 2'b01, 2'b01, 2'b11, 2'b11);
    frame_checked("f4_dir0",   1'b1, 5'd0,  322, 398, 2'b11, 2'b11, 2'b11, 2'b11);
    frame_checked("f5_dir18",  1'b1, 5'd18, 321, 397, 2'b11, 2'b11, 2'b01, 2'b01);

    // Walk right to X=602 while dir 19 keeps Y oscillating 398/397
    for (int j = 0; j < 281; j++) run_frame(1'b1, 5'd19);
    check_eq("walk1.x", bif.o_ballX, 602);
    check_eq("walk1.y", bif.o_ballY, 398);
    check_eq("walk1.sy", bif.o_speedY, 2'b11);
    frame_checked("wall_right", 1'b0, 5'd0, 603, 397, 2'b11, 2'b11, 2'b11, 2'b11);

    for (int j = 0; j < 392; j++) run_frame(1'b0, 5'd0);
    check_eq("walk2.x", bif.o_ballX, 211);
    check_eq("walk2.y", bif.o_ballY, 5);
    frame_checked("wall_top", 1'b0, 5'd0, 210, 4, 2'b11, 2'b01, 2'b11, 2'b01);

    // Down toward the loss line; left wall bounce at X=36 on the way
    for (int j = 0; j < 470; j++) run_frame(1'b0, 5'd0);
    check_eq("walk3.x", bif.o_ballX, 332);
    check_eq("walk3.y", bif.o_ballY, 474);
    check_eq("walk3.sx", bif.o_speedX, 2'b01);
    check_eq("walk3.sy", bif.o_speedY, 2'b01);

    // Loss
    base_r = req_rises;
    base_l = lost_cnt;
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    step();
    check_eq("loss.pulse", o_ball_lost, 1);
    check_eq("loss.x", bif.o_ballX, 320);
    check_eq("loss.y", bif.o_ballY, 400);
    check_eq("loss.sx", bif.o_speedX, 0);
    check_eq("loss.sy", bif.o_speedY, 0);
    check_eq("loss.busy", o_busy, 0);
    step();
    check_eq("loss.pulse_end", o_ball_lost, 0);
    repeat (4) step();
    check_eq("loss.count", lost_cnt - base_l, 1);
    check_eq("loss.no_req", req_rises - base_r, 0);
    $display("loss: x=%0d y=%0d lost_pulses=%0d", bif.o_ballX, bif.o_ballY, lost_cnt - base_l);

    // Delayed ack and a dropped tick during WAIT_ACK
    launch();
    base_r = req_rises;
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    step();
    check_eq("slow.x", bif.o_ballX, 321);
    check_eq("slow.y", bif.o_ballY, 399);
    step();
    check_eq("slow.req_rise", bif.o_brick_req, 1);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) i_frame_tick = 1'b1;
      step();
      i_frame_tick = 1'b0;
      check_eq("slow.req_hold", bif.o_brick_req, 1);
    end
    drive_ack(1'b1, 1'b0, 5'd0);
    step();
    drive_ack(1'b0, 1'b0, 5'd0);
    check_eq("slow.req_fall", bif.o_brick_req, 0);
    step();
    check_eq("slow.sx", bif.o_speedX, 2'b01);
    check_eq("slow.sy", bif.o_speedY, 2'b11);
    repeat (8) step();
    check_eq("slow.x_hold", bif.o_ballX, 321);
    check_eq("slow.y_hold", bif.o_ballY, 399);
    check_eq("slow.one_req", req_rises - base_r, 1);
    check_eq("slow.busy", o_busy, 0);
    $display("slow ack: x=%0d y=%0d reqs=%0d", bif.o_ballX, bif.o_ballY, req_rises - base_r);

    // Restart while waiting for ack
    base_l = lost_cnt;
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    step();
    step();
    step();
    check_eq("restart.req_before", bif.o_brick_req, 1);
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check_eq("restart.req", bif.o_brick_req, 0);
    check_eq("restart.busy", o_busy, 0);
    check_eq("restart.x", bif.o_ballX, 320);
    check_eq("restart.y", bif.o_ballY, 400);
    check_eq("restart.sx", bif.o_speedX, 0);
    drive_ack(1'b1, 1'b1, 5'd18);
    step();
    drive_ack(1'b0, 1'b0, 5'd0);
    step();
    check_eq("restart.idle_busy", o_busy, 0);
    check_eq("restart.idle_sx", bif.o_speedX, 0);
    check_eq("restart.no_lost", lost_cnt - base_l, 0);
    $display("restart: x=%0d y=%0d req=%0d", bif.o_ballX, bif.o_ballY, bif.o_brick_req);

    // Asynchronous reset mid-handshake
    launch();
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    step();
    step();
    check_eq("areset.req_before", bif.o_brick_req, 1);
    rst_n = 1'b0;
    #2;
    check_eq("areset.req", bif.o_brick_req, 0);
    check_eq("areset.x", bif.o_ballX, 320);
    check_eq("areset.busy", o_busy, 0);
    #2;
    rst_n = 1'b1;
    step();
    check_eq("areset.idle_sx", bif.o_speedX, 0);
    $display("async reset: req=%0d x=%0d", bif.o_brick_req, bif.o_ballX);

`ifdef BALL_TIMEOUT_EN
    begin
      int n;
      launch();
      i_frame_tick = 1'b1;
      step();
      i_frame_tick = 1'b0;
      step();
      step();
      check_eq("tmo.req_rise", bif.o_brick_req, 1);
      n = 0;
      while (!o_timeout && n < 40) begin
        step();
        n++;
      end
      check_eq("tmo.cycles", n, 15);
      check_eq("tmo.req", bif.o_brick_req, 0);
      step();
      check_eq("tmo.pulse_end", o_timeout, 0);
      check_eq("tmo.sx", bif.o_speedX, 2'b01);
      check_eq("tmo.sy", bif.o_speedY, 2'b11);
      check_eq("tmo.busy", o_busy, 0);
      $display("timeout: after %0d cycles", n);
    end
`else
    check_eq("no_tmo.timeout", o_timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
